// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, NOP word, RV32 field positions.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } ifu_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB = 0;
    localparam int OP_MSB = 6;
    localparam int F3_LSB = 12;
    localparam int F3_MSB = 14;
    localparam int F7_LSB = 25;
    localparam int F7_MSB = 31;

endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// Memory-ack watchdog: counts REQ cycles without ack; expire flags the last allowed cycle.
module ifu_timeout_ctr #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != LAST)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expire = (count_reg == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, imem req/ack handshake, registered instruction with decode slices.
// Optional macro IFU_MISALIGN_CHECK_EN faults on taken targets that are not word aligned.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              ACK_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            instr_ready,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            fetch_err
);

    ifu_state_t      state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     instr_reg;
    logic            accept;
    logic            misalign;
    logic            to_clr;
    logic            to_en;
    logic            to_expire;

    assign accept  = (state_reg == ST_VALID) && instr_ready;
    assign pc_next = pc_src ? pc_target : pc_reg + XLEN'(4);

`ifdef IFU_MISALIGN_CHECK_EN
    assign misalign = pc_src && (pc_target[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Counter runs only while waiting in REQ; an ack or leaving REQ restarts it.
    assign to_clr = (state_reg != ST_REQ) || imem_ack;
    assign to_en  = (state_reg == ST_REQ) && !imem_ack;

    ifu_timeout_ctr #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (to_clr),
        .en     (to_en),
        .expire (to_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= NOP_INSTR;
        end else begin
            case (state_reg)
                ST_IDLE: state_reg <= ST_REQ;
                ST_REQ: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (imem_ack) begin
                        instr_reg <= imem_rdata;
                        state_reg <= ST_VALID;
                    end else if (to_expire) begin
                        state_reg <= ST_ERR;
                    end
                end
                ST_VALID: begin
                    if (accept) begin
                        if (misalign) begin
                            state_reg <= ST_ERR;
                        end else begin
                            pc_reg    <= pc_next;
                            state_reg <= ST_REQ;
                        end
                    end
                end
                default: state_reg <= ST_ERR;
            endcase
        end
    end

    assign imem_req    = (state_reg == ST_REQ);
    assign instr_valid = (state_reg == ST_VALID);
    assign fetch_err   = (state_reg == ST_ERR);
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign op          = instr_reg[OP_MSB:OP_LSB];
    assign funct3      = instr_reg[F3_MSB:F3_LSB];
    assign funct7      = instr_reg[F7_MSB:F7_LSB];

endmodule
